// File: rtl/shifter_pkg.sv
// shifter_pkg: shared definitions for the sequential shifter/ALU.
//   shf_op_t : operation select encodings carried on shfc
//   state_t  : top-level control FSM states
package shifter_pkg;

  typedef enum logic [2:0] {
    SHF_SHL1 = 3'b000,  // f << 1
    SHF_MUL  = 3'b001,  // f * x, low W bits
    SHF_NOT  = 3'b010,  // ~f
    SHF_SRA  = 3'b011,  // f >>> 1, MSB replicated
    SHF_DIV  = 3'b100,  // f / x, unsigned quotient
    SHF_ZERO = 3'b101,  // all 0s
    SHF_ONES = 3'b110,  // all 1s
    SHF_ROTL = 3'b111   // f rotated left by x
  } shf_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shifter_seq_n_bit_if.sv
// shifter_seq_n_bit_if: request/result bundle for shifter_seq_n_bit.
//   start, shfc, in, x : request and operands (master -> slave)
//   out, done, busy, err : result and status (slave -> master)
interface shifter_seq_n_bit_if #(
  parameter int N_BITS = 4
);
  localparam int W = 2 ** N_BITS;

  logic              start;
  logic [2:0]        shfc;
  logic [W-1:0]      in;
  logic [N_BITS-1:0] x;
  logic [W-1:0]      out;
  logic              done;
  logic              busy;
  logic              err;

  modport master (output start, shfc, in, x, input out, done, busy, err);
  modport slave  (input start, shfc, in, x, output out, done, busy, err);

endinterface

// File: rtl/divider_restoring_n_bit.sv
// divider_restoring_n_bit: iterative restoring divider, one quotient bit per clock.
//   clk, rst  : clock, asynchronous active-high reset
//   start     : one-cycle pulse; dividend/divisor sampled on that edge
//   dividend  : W-bit unsigned dividend
//   divisor   : W-bit unsigned divisor, must be non-zero
//   done      : one-cycle pulse while quotient holds the final result
//   quotient  : W-bit unsigned quotient
// The first quotient bit is produced on the start edge itself, so done is
// high during the cycle after the W-th edge counted from start (edge W-1).
module divider_restoring_n_bit #(
  parameter int N_BITS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [2**N_BITS-1:0]   dividend,
  input  logic [2**N_BITS-1:0]   divisor,
  output logic                   done,
  output logic [2**N_BITS-1:0]   quotient
);
  localparam int W = 2 ** N_BITS;

  logic [W-1:0]      rem_reg, rem_next;
  logic [W-1:0]      quo_reg, quo_next;
  logic [W-1:0]      dvs_reg, dvs_next;
  logic [N_BITS-1:0] cnt_reg, cnt_next;
  logic              run_reg, run_next;
  logic              done_reg, done_next;

  logic [W-1:0] src_rem, src_quo, src_dvs;
  logic [W:0]   shifted, trial;

  always_comb begin
    // On start the step works directly on the fresh operands.
    src_rem = start ? '0 : rem_reg;
    src_quo = start ? dividend : quo_reg;
    src_dvs = start ? divisor : dvs_reg;
    shifted = {src_rem, src_quo[W-1]};
    trial   = shifted - {1'b0, src_dvs};

    rem_next  = rem_reg;
    quo_next  = quo_reg;
    dvs_next  = dvs_reg;
    cnt_next  = cnt_reg;
    run_next  = run_reg;
    done_next = 1'b0;

    if (start || run_reg) begin
      // Remainder stays below the divisor, so a negative trial shows up as
      // the extra top bit; in that case the shifted remainder is restored.
      rem_next = trial[W] ? shifted[W-1:0] : trial[W-1:0];
      quo_next = {src_quo[W-2:0], ~trial[W]};
      dvs_next = src_dvs;
      if (start) begin
        cnt_next = N_BITS'(W - 1);
        run_next = 1'b1;
      end else begin
        cnt_next = cnt_reg - N_BITS'(1);
        if (cnt_reg == N_BITS'(1)) begin
          run_next  = 1'b0;
          done_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_reg  <= '0;
      quo_reg  <= '0;
      dvs_reg  <= '0;
      cnt_reg  <= '0;
      run_reg  <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      rem_reg  <= rem_next;
      quo_reg  <= quo_next;
      dvs_reg  <= dvs_next;
      cnt_reg  <= cnt_next;
      run_reg  <= run_next;
      done_reg <= done_next;
    end
  end

  assign done     = done_reg;
  assign quotient = quo_reg;

endmodule

// File: rtl/shifter_seq_n_bit.sv
// shifter_seq_n_bit: sequential shift/arithmetic unit, W = 2**N_BITS bits.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : shifter_seq_n_bit_if.slave
//              start/shfc/in/x in; out/done/busy/err out (all registered)
// A request is accepted on an edge where start=1 and the unit is idle; the
// operands are captured then and later input changes are ignored. The result
// lands in out on the edge that raises done, and done/busy decode the state
// register only, so no input reaches an output combinationally.
module shifter_seq_n_bit
  import shifter_pkg::*;
#(
  parameter int N_BITS = 4
) (
  input  logic               clk,
  input  logic               rst,
  shifter_seq_n_bit_if.slave bus
);
  localparam int W = 2 ** N_BITS;

  state_t            state_reg, state_next;
  shf_op_t           op_reg, op_next;
  logic [W-1:0]      a_reg, a_next;      // operand / multiplicand / rotating value
  logic [W-1:0]      acc_reg, acc_next;  // multiply accumulator
  logic [W-1:0]      out_reg, out_next;
  logic [N_BITS-1:0] x_reg, x_next;      // operand x / remaining multiplier bits
  logic [N_BITS-1:0] cnt_reg, cnt_next;  // remaining RUN cycles minus one
  logic              err_reg, err_next;

  logic         div_start, div_done, finish;
  logic [W-1:0] div_q, mul_step, rot_step, result;

  assign div_start = (state_reg == IDLE) && bus.start &&
                     (shf_op_t'(bus.shfc) == SHF_DIV) && (bus.x != '0);

  divider_restoring_n_bit #(.N_BITS(N_BITS)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (bus.in),
    .divisor  (W'(bus.x)),
    .done     (div_done),
    .quotient (div_q)
  );

  always_comb begin
    mul_step = acc_reg + (x_reg[0] ? a_reg : '0);
    // x=0 rotates by nothing but still spends one cycle.
    rot_step = (x_reg == '0) ? a_reg : {a_reg[W-2:0], a_reg[W-1]};
    case (op_reg)
      SHF_SHL1: result = a_reg << 1;
      SHF_MUL:  result = mul_step;
      SHF_NOT:  result = ~a_reg;
      SHF_SRA:  result = {a_reg[W-1], a_reg[W-1:1]};
      SHF_DIV:  result = (x_reg == '0) ? '1 : div_q;
      SHF_ZERO: result = '0;
      SHF_ONES: result = '1;
      SHF_ROTL: result = rot_step;
      default:  result = '0;
    endcase
    // Division is paced by the divider; everything else by cnt_reg.
    finish = (op_reg == SHF_DIV) ? ((x_reg == '0) || div_done) : (cnt_reg == '0);
  end

  always_comb begin
    state_next = state_reg;
    op_next    = op_reg;
    a_next     = a_reg;
    acc_next   = acc_reg;
    x_next     = x_reg;
    cnt_next   = cnt_reg;
    out_next   = out_reg;
    err_next   = err_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next = RUN;
          op_next    = shf_op_t'(bus.shfc);
          a_next     = bus.in;
          x_next     = bus.x;
          acc_next   = '0;
          case (shf_op_t'(bus.shfc))
            SHF_MUL:  cnt_next = N_BITS'(N_BITS - 1);
            SHF_ROTL: cnt_next = (bus.x == '0) ? '0 : bus.x - N_BITS'(1);
            default:  cnt_next = '0;
          endcase
        end
      end
      RUN: begin
        if (op_reg == SHF_MUL) begin
          acc_next = mul_step;
          a_next   = a_reg << 1;
          x_next   = x_reg >> 1;
        end else if (op_reg == SHF_ROTL) begin
          a_next = rot_step;
        end
        if (finish) begin
          state_next = DONE;
          out_next   = result;
          err_next   = (op_reg == SHF_DIV) && (x_reg == '0);
        end else if (op_reg != SHF_DIV) begin
          cnt_next = cnt_reg - N_BITS'(1);
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      op_reg    <= SHF_SHL1;
      a_reg     <= '0;
      acc_reg   <= '0;
      out_reg   <= '0;
      x_reg     <= '0;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      op_reg    <= op_next;
      a_reg     <= a_next;
      acc_reg   <= acc_next;
      out_reg   <= out_next;
      x_reg     <= x_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
    end
  end

  assign bus.out  = out_reg;
  assign bus.done = (state_reg == DONE);
  assign bus.busy = (state_reg != IDLE);
  assign bus.err  = err_reg;

endmodule

// File: tb/tb_shifter_seq_n_bit.sv
// tb_shifter_seq_n_bit: self-checking bench for shifter_seq_n_bit (N_BITS=3, W=8).
// Directed cases with literal expectations, then randomized back-to-back
// requests over all eight operations checked against an arithmetic model.
module tb_shifter_seq_n_bit;
  localparam int NB = 3;
  localparam int W  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;

  shifter_seq_n_bit_if #(.N_BITS(NB)) bus ();

  shifter_seq_n_bit #(.N_BITS(NB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Behavioural reference: result, error flag and latency from plain arithmetic.
  function automatic void ref_model(input logic [2:0] op, input logic [7:0] f,
                                    input logic [2:0] x, output logic [7:0] r,
                                    output logic e, output int lat);
    logic [15:0] wide;
    e   = 1'b0;
    lat = 1;
    r   = 8'h00;
    case (op)
      3'd0: r = f << 1;
      3'd1: begin wide = 16'(f) * 16'(x); r = wide[7:0]; lat = NB; end
      3'd2: r = ~f;
      3'd3: r = 8'($signed(f) >>> 1);
      3'd4: begin
        if (x == 3'd0) begin r = 8'hFF; e = 1'b1; end
        else begin r = f / 8'(x); lat = W; end
      end
      3'd5: r = 8'h00;
      3'd6: r = 8'hFF;
      3'd7: begin
        wide = {f, f} << x;
        r    = wide[15:8];
        lat  = (x == 3'd0) ? 1 : int'(x);
      end
      default: r = 8'h00;
    endcase
  endfunction

  // Entered #1 after an edge with busy=0; leaves #1 after the DONE->IDLE edge.
  task automatic run_op(input logic [2:0] op, input logic [7:0] f, input logic [2:0] x,
                        input logic [7:0] exp_out, input logic exp_err, input int exp_lat,
                        input bit inject);
    logic [7:0] prev_out;
    logic       prev_err;
    bit         hold_ok;
    int         lat;
    prev_out = bus.out;
    prev_err = bus.err;
    hold_ok  = 1'b1;
    lat      = 0;
    bus.start = 1'b1;
    bus.shfc  = op;
    bus.in    = f;
    bus.x     = x;
    @(posedge clk); #1;
    chk("busy_at_accept", 32'(bus.busy), 32'd1);
    // Scramble operands; optionally keep start high to check it is ignored.
    bus.start = inject;
    bus.shfc  = 3'($urandom);
    bus.in    = 8'($urandom);
    bus.x     = 3'($urandom);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        lat = k;
        break;
      end
      if (bus.out !== prev_out || bus.err !== prev_err || bus.busy !== 1'b1) hold_ok = 1'b0;
    end
    bus.start = 1'b0;
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("out", 32'(bus.out), 32'(exp_out));
    chk("err", 32'(bus.err), 32'(exp_err));
    chk("busy_at_done", 32'(bus.busy), 32'd1);
    chk("hold_in_flight", 32'(hold_ok), 32'd1);
    $display("op=%0d f=0x%02h x=%0d inject=%0b -> out=0x%02h err=%0b lat=%0d",
             op, f, x, inject, bus.out, bus.err, lat);
    @(posedge clk); #1;
    chk("done_single", 32'(bus.done), 32'd0);
    chk("idle_after", 32'(bus.busy), 32'd0);
  endtask

  task automatic run_rand(input logic [2:0] op, input logic [7:0] f, input logic [2:0] x,
                          input bit inject);
    logic [7:0] r;
    logic       e;
    int         lat;
    ref_model(op, f, x, r, e, lat);
    run_op(op, f, x, r, e, lat, inject);
  endtask

  initial begin
    bit       rst_ok;
    logic [2:0] rx;
    bus.start = 1'b0;
    bus.shfc  = 3'd0;
    bus.in    = 8'h00;
    bus.x     = 3'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", 32'(bus.out), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    rst = 1'b0;

    // Directed cases with literal expectations
    run_op(3'd1, 8'd13,  3'd5, 8'd65,  1'b0, 3, 1'b0);
    run_op(3'd1, 8'd200, 3'd7, 8'd120, 1'b0, 3, 1'b0);
    run_op(3'd4, 8'd200, 3'd7, 8'd28,  1'b0, 8, 1'b0);
    run_op(3'd4, 8'd200, 3'd0, 8'hFF,  1'b1, 1, 1'b0);
    run_op(3'd7, 8'h81,  3'd3, 8'h0C,  1'b0, 3, 1'b0);
    run_op(3'd3, 8'h90,  3'd0, 8'hC8,  1'b0, 1, 1'b0);
    run_op(3'd7, 8'h5A,  3'd0, 8'h5A,  1'b0, 1, 1'b0);
    run_op(3'd4, 8'd255, 3'd1, 8'd255, 1'b0, 8, 1'b0);
    run_op(3'd0, 8'h81,  3'd2, 8'h02,  1'b0, 1, 1'b0);
    // Second start held high during a divide is ignored
    run_op(3'd4, 8'd200, 3'd7, 8'd28,  1'b0, 8, 1'b1);
    run_op(3'd6, 8'h00,  3'd0, 8'hFF,  1'b0, 1, 1'b0);

    // Reset in the middle of a divide
    bus.start = 1'b1;
    bus.shfc  = 3'd4;
    bus.in    = 8'd100;
    bus.x     = 3'd3;
    @(posedge clk); #1;           // accepting edge
    repeat (4) @(posedge clk);    // edge 4 of the operation
    #1;
    rst = 1'b1;
    #1;
    chk("abort_out", 32'(bus.out), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_err", 32'(bus.err), 32'd0);
    rst_ok = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) rst_ok = 1'b0;
      if (k == 2) rst = 1'b0;
      if (k == 2) break;
    end
    chk("quiet_in_reset", 32'(rst_ok), 32'd1);
    bus.start = 1'b0;
    run_op(3'd4, 8'd100, 3'd3, 8'd33, 1'b0, 8, 1'b0);

    // Randomized back-to-back requests, every operation in each round
    for (int r = 0; r < 10; r++) begin
      for (int o = 0; o < 8; o++) begin
        rx = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom);
        run_rand(3'(o), 8'($urandom), rx, $urandom_range(0, 3) == 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
